spi_slave_rx: RTL and testbench

SPI mode-0 slave receiver/responder for the clk-domain SPI bus. It deserialises MSB-first WIDTH-bit words from an SPI master (active-low chip select, one-clk-minimum sclk phases) into a holding register with a valid/ready handshake. It simultaneously shifts a response word out on MISO. It sits at the far end of the SPI link, paired with the team's SPI master, and feeds a downstream consumer.

---
 rtl/spi_slave_rx.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   SPI mode-0 slave. It deserialises MSB-first WIDTH-bit words from MOSI into a
//   holding register with a valid/ready handshake. At the same time it shifts a
//   response word out on MISO. All SPI inputs are synchronised into the clk
//   domain through identical SYNC_STAGES chains, so they stay mutually aligned.
//
// Ports
//   clk, reset  : system clock, asynchronous active-high reset
//   spi_cs      : chip select, active low
//   spi_sclk    : serial clock from master, idle low
//   spi_mosi    : serial data from master
//   spi_miso    : serial response data to master
//   tx_data     : response word, captured at frame start and on word wrap
//   rx_data     : last received word (holding register)
//   rx_valid    : rx_data holds an unconsumed word
//   rx_ready    : consumer accepts rx_data when rx_valid & rx_ready
//   overrun     : 1-cycle pulse, completed word dropped because holding register full
//   frame_err   : 1-cycle pulse, chip select released mid-word
//   bit_count   : bits received in the current word, 0..WIDTH-1
module spi_slave_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic [4:0]       bit_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_s, sclk_s, mosi_s;
  logic cs_d, sclk_d;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [WIDTH-1:0] tx_sh, tx_sh_n;
  logic [WIDTH-2:0] rx_sh, rx_sh_n;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] rx_data_n;
  logic [4:0]       bit_cnt_n;
  logic             rx_valid_n, overrun_n, frame_err_n;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall   =  cs_d   & ~cs_s;
  assign cs_rise   = ~cs_d   &  cs_s;
  assign sclk_rise = ~sclk_d &  sclk_s;
  assign sclk_fall =  sclk_d & ~sclk_s;

  // MISO is the top of the tx shifter; clearing the shifter idles the line low.
  assign spi_miso = tx_sh[WIDTH-1];
  assign rx_word  = {rx_sh, mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      tx_sh     <= tx_sh_n;
      rx_sh     <= rx_sh_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      overrun   <= overrun_n;
      frame_err <= frame_err_n;
      bit_count <= bit_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    tx_sh_n     = tx_sh;
    rx_sh_n     = rx_sh;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid;
    overrun_n   = 1'b0;
    frame_err_n = 1'b0;
    bit_cnt_n   = bit_count;

    // Consumer handshake; a completion in the same cycle overrides this below.
    if (rx_valid && rx_ready)
      rx_valid_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n   = ACTIVE;
          tx_sh_n   = tx_data;
          rx_sh_n   = '0;
          bit_cnt_n = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n     = IDLE;
          tx_sh_n     = '0;
          rx_sh_n     = '0;
          bit_cnt_n   = '0;
          frame_err_n = (bit_count != '0);
        end else if (sclk_rise) begin
          rx_sh_n = rx_word[WIDTH-2:0];
          if (bit_count == LAST_BIT) begin
            bit_cnt_n = '0;
            if (!rx_valid || rx_ready) begin
              rx_data_n  = rx_word;
              rx_valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_count + 5'd1;
          end
        end else if (sclk_fall) begin
          // bit_count is 0 on a fall only right after a word wrapped: reload.
          if (bit_count == '0)
            tx_sh_n = tx_data;
          else
            tx_sh_n = {tx_sh[WIDTH-2:0], 1'b0};
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs, spi_sclk, spi_mosi;
  logic        spi_miso;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        overrun, frame_err;
  logic [4:0]  bit_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int ov_cnt   = 0;
  int fe_cnt   = 0;
  logic ov_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [15:0] hs_q[$];

  always #5 clk = ~clk;

  spi_slave_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .bit_count (bit_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulse monitor and handshake recorder, sampled mid low phase of clk.
  always @(negedge clk) begin
    #1;
    if (overrun) begin
      ov_cnt++;
      check("overrun_width", ov_prev, 1'b0);
    end
    if (frame_err) begin
      fe_cnt++;
      check("frame_err_width", fe_prev, 1'b0);
    end
    ov_prev = overrun;
    fe_prev = frame_err;
    if (rx_valid && rx_ready) hs_q.push_back(rx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit: MISO sampled as sclk rises, MOSI held for the whole high phase.
  task automatic spi_bit(input logic b, input int half, output logic m);
    m = spi_miso;
    spi_mosi = b;
    spi_sclk = 1'b1;
    wait_cyc(half);
    spi_sclk = 1'b0;
    wait_cyc(half);
  endtask

  task automatic spi_word(input logic [15:0] w, input int half, output logic [15:0] cap);
    logic m;
    for (int i = 15; i >= 0; i--) begin
      spi_bit(w[i], half, m);
      cap[i] = m;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    wait_cyc(5);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] mosi_word;
    logic [15:0] tx_word;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] cap, cap2, w;
    logic m;
    int ov_base, fe_base;

    vecs[0] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A};
    vecs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    vecs[3] = '{16'h8001, 16'h8000, 16'h8001, 16'h8000};

    reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    rx_ready = 1'b0; tx_data = 16'h0000;
    wait_cyc(3);
    check("reset_miso", spi_miso, 1'b0);
    check("reset_rx_data", rx_data, 16'h0000);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_bit_count", bit_count, 5'd0);
    reset = 1'b0;
    wait_cyc(3);

    // Single frame with bit_count stepping and exact completion latency.
    w = 16'hA5C3;
    fe_base = fe_cnt; ov_base = ov_cnt;
    cs_low();
    for (int i = 15; i >= 1; i--) begin
      spi_bit(w[i], 2, m);
      check("bit_count_step", bit_count, 5'(16 - i));
    end
    spi_mosi = w[0];
    spi_sclk = 1'b1;
    @(negedge clk);
    check("last_bit_count_before", bit_count, 5'd15);
    check("rx_valid_at_N", rx_valid, 1'b0);
    @(negedge clk);
    check("rx_valid_at_N1", rx_valid, 1'b0);
    @(negedge clk);
    check("rx_valid_at_N2", rx_valid, 1'b1);
    check("rx_data_at_N2", rx_data, 16'hA5C3);
    check("bit_count_wrap", bit_count, 5'd0);
    spi_sclk = 1'b0;
    wait_cyc(2);
    cs_high();
    check("single_no_frame_err", fe_cnt - fe_base, 0);
    check("single_no_overrun", ov_cnt - ov_base, 0);
    consume();
    check("single_consumed", rx_valid, 1'b0);

    // Table of full frames with response capture.
    foreach (vecs[k]) begin
      fe_base = fe_cnt; ov_base = ov_cnt;
      tx_data = vecs[k].tx_word;
      cs_low();
      spi_word(vecs[k].mosi_word, 4, cap);
      cs_high();
      check("vec_rx_data", rx_data, vecs[k].exp_rx);
      check("vec_rx_valid", rx_valid, 1'b1);
      check("vec_miso_word", cap, vecs[k].exp_miso);
      check("vec_miso_idle", spi_miso, 1'b0);
      check("vec_bit_count", bit_count, 5'd0);
      check("vec_no_errors", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);
      consume();
      check("vec_consumed", rx_valid, 1'b0);
    end

    // Back-to-back words within one frame, consumer always ready.
    hs_q.delete();
    ov_base = ov_cnt;
    rx_ready = 1'b1;
    tx_data = 16'h1357;
    cs_low();
    spi_word(16'h1234, 4, cap);
    spi_word(16'hFFFF, 4, cap2);
    cs_high();
    rx_ready = 1'b0;
    check("b2b_handshakes", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      check("b2b_word0", hs_q[0], 16'h1234);
      check("b2b_word1", hs_q[1], 16'hFFFF);
    end
    check("b2b_no_overrun", ov_cnt - ov_base, 0);
    check("b2b_miso_word0", cap, 16'h1357);
    check("b2b_miso_reload", cap2, 16'h1357);
    check("b2b_valid_clear", rx_valid, 1'b0);

    // Overrun: second completion while holding register is full.
    ov_base = ov_cnt;
    cs_low();
    spi_word(16'h00FF, 4, cap);
    check("ovr_first_valid", rx_valid, 1'b1);
    check("ovr_first_data", rx_data, 16'h00FF);
    spi_word(16'hFF00, 4, cap);
    cs_high();
    check("ovr_data_kept", rx_data, 16'h00FF);
    check("ovr_valid_kept", rx_valid, 1'b1);
    check("ovr_pulses", ov_cnt - ov_base, 1);
    consume();
    check("ovr_consumed", rx_valid, 1'b0);

    // Abort after 7 bits, then a clean frame.
    fe_base = fe_cnt;
    cs_low();
    for (int i = 0; i < 7; i++) spi_bit(1'(i % 2), 4, m);
    check("abort_bit_count", bit_count, 5'd7);
    cs_high();
    check("abort_frame_err", fe_cnt - fe_base, 1);
    check("abort_valid", rx_valid, 1'b0);
    check("abort_bit_count_clr", bit_count, 5'd0);
    cs_low();
    spi_word(16'h0001, 4, cap);
    cs_high();
    check("abort_next_data", rx_data, 16'h0001);
    check("abort_next_valid", rx_valid, 1'b1);
    check("abort_no_more_err", fe_cnt - fe_base, 1);
    consume();

    // Asynchronous reset after 9 bits.
    fe_base = fe_cnt;
    tx_data = 16'h0040;
    cs_low();
    for (int i = 0; i < 9; i++) spi_bit(1'b1, 4, m);
    check("pre_reset_bit_count", bit_count, 5'd9);
    check("pre_reset_miso", spi_miso, 1'b1);
    reset = 1'b1;
    spi_cs = 1'b1;
    #1;
    check("mid_reset_miso", spi_miso, 1'b0);
    check("mid_reset_rx_data", rx_data, 16'h0000);
    check("mid_reset_rx_valid", rx_valid, 1'b0);
    check("mid_reset_pulses", {overrun, frame_err}, 2'b00);
    check("mid_reset_bit_count", bit_count, 5'd0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
    cs_low();
    spi_word(16'hBEEF, 4, cap);
    cs_high();
    check("post_reset_data", rx_data, 16'hBEEF);
    check("post_reset_valid", rx_valid, 1'b1);
    check("post_reset_no_frame_err", fe_cnt - fe_base, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
